// File: rtl/mat_mul_arbiter.sv
// Shares one matmul engine between NUM_REQ requesters with 0-cycle grant and in-order tagged responses;
// MM_ARB_FIXED_PRIO_EN selects fixed priority. A blocked head response drops eng_cen, freezing engine and issue.

module mm_arb_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CW-1:0]    count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (pop_i && !push_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is only consulted when count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

module mat_mul_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int IDW        = $clog2(NUM_REQ),
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [IDW-1:0]                grant_sel,
  output logic                          eng_valid_in,
  output logic                          eng_cen,
  input  logic                          eng_valid_out,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  input  logic                          drain_req,
  output logic                          halted,
  output logic [$clog2(FIFO_DEPTH):0]   in_flight,
  output logic                          err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t         state_q;
  logic           halted_q;
  logic           err_q, err_d;
  logic [IDW-1:0] head_tag;
  logic [CW-1:0]  count;
  logic           fifo_empty, rsp_hit, stall, pop, can_issue, issue;
  logic [IDW-1:0] win;
  logic           found;

  assign fifo_empty = (count == '0);
  // A result arriving with no owner is dropped: it neither stalls nor pops.
  assign rsp_hit    = eng_valid_out & ~fifo_empty;
  assign stall      = rsp_hit & ~rsp_ready[head_tag];
  assign pop        = rsp_hit & rsp_ready[head_tag];
  assign can_issue  = (state_q == RUN) & ~stall & (count < CW'(FIFO_DEPTH));
  assign issue      = can_issue & found;

`ifdef MM_ARB_FIXED_PRIO_EN
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win   = IDW'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] rr_idx;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    win    = '0;
    found  = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = IDW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && req_valid[rr_idx]) begin
        win   = rr_idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      last_grant_q <= IDW'(NUM_REQ - 1);
    else if (issue) last_grant_q <= win;
  end
`endif

  mm_arb_tag_fifo #(
    .WIDTH (IDW),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (issue),
    .push_dat_i (win),
    .pop_i      (pop),
    .head_dat_o (head_tag),
    .count_o    (count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: if (drain_req) state_q <= DRAIN;
        DRAIN: begin
          if (!drain_req) begin
            state_q <= RUN;
          end else if (fifo_empty && !eng_valid_out) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          if (!drain_req) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign err_d = err_q | (eng_valid_out & fifo_empty);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign req_ready    = issue ? (NUM_REQ'(1) << win) : '0;
  assign grant_sel    = issue ? win : '0;
  assign eng_valid_in = issue;
  assign eng_cen      = ~stall;
  assign rsp_valid    = rsp_hit ? (NUM_REQ'(1) << head_tag) : '0;
  assign halted       = halted_q;
  assign in_flight    = count;
  assign err          = err_q;
endmodule
